fill_cache_pack: RTL and testbench
==================================

// Module: fill_cache_pack
// PURPOSE
//  Second-generation tile cache filler for the video calc path.
//  - Fetches a W x H pixel tile from the image in external RAM over Wishbone (classic, single read per STB/ACK).
//  - Unpacks PIX_PER_WORD pixels per bus word and writes one pixel per cycle into the internal cache RAM.
//  - The tile origin may lie partly outside the image. Out-of-image pixels get BORDER_VAL and cost no bus access.
// PARAMETERS
//  IM_WIDTH     640  image width in pixels; must be a multiple of PIX_PER_WORD
//  IM_HEIGHT    480  image height in pixels
//  ADDR_SIZE_W  5    cache max width  = 2**ADDR_SIZE_W
//  ADDR_SIZE_H  5    cache max height = 2**ADDR_SIZE_H
//  PIX_W        8    bits per pixel; 8, 16 or 32
//  BORDER_VAL   0    value written for pixels outside the image
//  (derived) PIX_PER_WORD = 32/PIX_W
// PORTS
//  clk          in   1                      system clock
//  nRST         in   1                      async reset, active low
//  pixel_c_I    in   11 (signed)            tile origin column, may be negative
//  pixel_l_I    in   11 (signed)            tile origin line, may be negative
//  cache_w_I    in   ADDR_SIZE_W+1          tile width; 0 = empty tile
//  cache_h_I    in   ADDR_SIZE_H+1          tile height; 0 = empty tile
//  im_addr_I    in   32                     image base byte address, word aligned
//  go           in   1                      start pulse, sampled in IDLE only
//  busy         out  1                      high from go until done
//  cache_ready  out  1                      one-cycle pulse, tile complete
//  p_wb_DAT_I   in   32                     read data
//  p_wb_ACK_I   in   1                      acknowledge
//  p_wb_STB_O   out  1                      strobe
//  p_wb_CYC_O   out  1                      cycle
//  p_wb_LOCK_O  out  1                      tied 0
//  p_wb_SEL_O   out  4                      tied 4'hF
//  p_wb_WE_O    out  1                      tied 0
//  p_wb_ADR_O   out  32                     byte address
//  pixels_out   out  PIX_W                  pixel to cache RAM
//  ram_addr     out  ADDR_SIZE_W+ADDR_SIZE_H  cache address = line*2**ADDR_SIZE_W + col
//  w_e          out  1                      cache RAM write enable
// BEHAVIOUR
//  Reset:
//  - All outputs reset to 0, except p_wb_SEL_O = 4'hF.
//  - State returns to IDLE; counters clear.
//  - Reset mid-tile abandons the tile. CYC and STB drop asynchronously.
//  Sampling:
//  - On go in IDLE, all *_I inputs are registered.
//  - cache_w/h values above the maximum clamp to 2**ADDR_SIZE_W / 2**ADDR_SIZE_H.
//  - go while busy is ignored.
//  States:
//  - IDLE: waits for go. If w==0 or h==0, go -> DONE; otherwise -> PIXEL.
//  - PIXEL: evaluates the current (l,c) = origin + (cnt_line, cnt_col).
//    - Outside the image (l<0, l>=IM_HEIGHT, c<0, c>=IM_WIDTH): write BORDER_VAL this cycle (w_e=1), then advance.
//    - Inside the image, with the current word already buffered (same line, same word index): write the buffered lane, then advance.
//    - Otherwise -> REQ.
//  - REQ:
//    - Drive CYC=STB=1 with ADR = im_addr + ((l*IM_WIDTH + c)/PIX_PER_WORD)*4.
//    - Hold until ACK. On ACK, latch DAT_I into the word buffer with its tag (l, word index), drop STB/CYC, -> PIXEL.
//  - DONE: cache_ready=1 for exactly one cycle, busy=0, -> IDLE.
//  Unpacking and counters:
//  - Lane selection is little-endian: lane = c mod PIX_PER_WORD, bits [lane*PIX_W +: PIX_W].
//  - Advance: cnt_col++; at cnt_col==w-1, cnt_col=0 and cnt_line++.
//  - At the last pixel (cnt_line==h-1 and cnt_col==w-1), -> DONE.
//  Timing:
//  - One cache write per PIXEL cycle.
//  - The buffer tag is invalidated on go and at each line change.
//  - Coordinate arithmetic is 12-bit signed, so origin+count never wraps. The address product uses 32-bit unsigned after the range check.
//  - A zero-latency ACK (ACK asserted in the first REQ cycle) is legal and completes the REQ in one cycle.
// CONFIGURATION
//  FILL_CACHE_PACK_ERR_EN: adds input p_wb_ERR_I and output err (1 bit, reset 0).
//  - With the macro: ERR in REQ ends the cycle (CYC/STB drop) and the tile is aborted without further writes.
//    err is set and sticky until the next accepted go, and cache_ready still pulses once.
//  - Without the macro: no ERR port or err port, and a bus error hangs in REQ until ACK.
// STRUCTURE
//  Package fill_cache_pkg:
//  - state enum {IDLE, PIXEL, REQ, DONE}
//  - PIX_PER_WORD / lane-index helper function
//  - signed coordinate typedef coord_t (12 bits)
//  Sub-module fill_cache_lane_sel: combinational word buffer lane mux (word, lane -> pixel).
// TESTING
//  1. PIX_W=8, origin (0,0), w=h=4, im_addr=0x1000, RAM word = {l,c..} pattern
//     -> 4 bus reads at 0x1000, 0x1280, 0x1500, 0x1780; 16 writes; one cache_ready pulse.
//  2. Origin (-2,-1), w=h=4 -> row 0 and cols 0-1 get BORDER_VAL with no bus access; 3 reads total; pixel (1,2) = image (0,0).
//  3. Origin (638,478), w=h=4 -> only image pixels (478..479, 638..639) are read (2 reads); the remaining 12 writes are BORDER_VAL.
//  4. w=0, go -> no bus activity; cache_ready pulses 2 cycles after go. go pulsed again while busy -> ignored.
//  5. ACK delayed by 5 cycles then zero-latency -> CYC/STB held stable through the wait; data and ram_addr sequence unchanged.
//  6. nRST low during REQ -> CYC/STB drop immediately; a restart with go completes a clean tile.
//     With FILL_CACHE_PACK_ERR_EN, ERR on the 2nd read -> err=1, no further w_e, cache_ready pulses once.

Source files
------------

// File: rtl/fill_cache_pkg.sv
// Shared types and helpers for the tile cache filler.
package fill_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PIXEL = 2'd1,
    REQ   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned COORD_W = 12;
  typedef logic signed [COORD_W-1:0] coord_t;

  function automatic int unsigned pix_per_word(input int unsigned pix_w);
    return 32 / pix_w;
  endfunction

  // Little-endian lane of column c inside its bus word.
  function automatic logic [1:0] lane_idx(input coord_t c, input int unsigned ppw);
    return 2'(32'(unsigned'(c)) % ppw);
  endfunction

endpackage

// File: rtl/fill_cache_lane_sel.sv
// Word buffer lane mux: picks one pixel out of a 32-bit bus word.
module fill_cache_lane_sel #(
  parameter int unsigned PIX_W = 8
) (
  input  logic [31:0]      word,
  input  logic [1:0]       lane,
  output logic [PIX_W-1:0] pix_c
);

  always_comb pix_c = PIX_W'(word >> (32'(lane) * PIX_W));

endmodule

// File: rtl/fill_cache_pack.sv
// Tile cache filler: fetches a W x H tile over Wishbone and writes it pixel by pixel.
// Optional bus error handling is enabled with FILL_CACHE_PACK_ERR_EN.
module fill_cache_pack
  import fill_cache_pkg::*;
#(
  parameter int unsigned       IM_WIDTH    = 640,
  parameter int unsigned       IM_HEIGHT   = 480,
  parameter int unsigned       ADDR_SIZE_W = 5,
  parameter int unsigned       ADDR_SIZE_H = 5,
  parameter int unsigned       PIX_W       = 8,
  parameter logic [PIX_W-1:0]  BORDER_VAL  = '0
) (
  input  logic                              clk,
  input  logic                              nRST,
  input  logic signed [10:0]                pixel_c_I,
  input  logic signed [10:0]                pixel_l_I,
  input  logic [ADDR_SIZE_W:0]              cache_w_I,
  input  logic [ADDR_SIZE_H:0]              cache_h_I,
  input  logic [31:0]                       im_addr_I,
  input  logic                              go,
  output logic                              busy,
  output logic                              cache_ready,
  input  logic [31:0]                       p_wb_DAT_I,
  input  logic                              p_wb_ACK_I,
  output logic                              p_wb_STB_O,
  output logic                              p_wb_CYC_O,
  output logic                              p_wb_LOCK_O,
  output logic [3:0]                        p_wb_SEL_O,
  output logic                              p_wb_WE_O,
  output logic [31:0]                       p_wb_ADR_O,
  output logic [PIX_W-1:0]                  pixels_out,
  output logic [ADDR_SIZE_W+ADDR_SIZE_H-1:0] ram_addr,
`ifdef FILL_CACHE_PACK_ERR_EN
  input  logic                              p_wb_ERR_I,
  output logic                              err,
`endif
  output logic                              w_e
);

  localparam int unsigned PPW = pix_per_word(PIX_W);
  localparam int unsigned CW  = ADDR_SIZE_W + 1;
  localparam int unsigned CH  = ADDR_SIZE_H + 1;
  localparam int unsigned AW  = ADDR_SIZE_W + ADDR_SIZE_H;
  localparam logic [CW-1:0] W_MAX = CW'(1 << ADDR_SIZE_W);
  localparam logic [CH-1:0] H_MAX = CH'(1 << ADDR_SIZE_H);

  state_e              state_q, state_d;
  coord_t              org_c_q, org_c_d, org_l_q, org_l_d;
  logic [CW-1:0]       w_q, w_d, cnt_col_q, cnt_col_d;
  logic [CH-1:0]       h_q, h_d, cnt_line_q, cnt_line_d;
  logic [31:0]         base_q, base_d, buf_q, buf_d;
  logic                tag_vld_q, tag_vld_d;
  coord_t              tag_l_q, tag_l_d;
  logic [COORD_W-1:0]  tag_w_q, tag_w_d;
  logic                busy_q, busy_d, ready_q, ready_d, cyc_q, cyc_d, we_q, we_d;
  logic [31:0]         adr_q, adr_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [AW-1:0]       ram_addr_q, ram_addr_d;
  logic                err_q, err_d;

  coord_t              cur_l, cur_c;
  logic [COORD_W-1:0]  widx;
  logic                in_img, hit;
  logic [PIX_W-1:0]    lane_pix;

  // Current image coordinate and whether the word buffer already holds it.
  always_comb begin
    cur_l  = org_l_q + coord_t'(cnt_line_q);
    cur_c  = org_c_q + coord_t'(cnt_col_q);
    widx   = COORD_W'(32'(unsigned'(cur_c)) / PPW);
    in_img = !cur_l[COORD_W-1] && !cur_c[COORD_W-1] &&
             (cur_l < coord_t'(IM_HEIGHT)) && (cur_c < coord_t'(IM_WIDTH));
    hit    = tag_vld_q && (tag_l_q == cur_l) && (tag_w_q == widx);
  end

  fill_cache_lane_sel #(.PIX_W(PIX_W)) u_lane_sel (
    .word  (buf_q),
    .lane  (lane_idx(cur_c, PPW)),
    .pix_c (lane_pix)
  );

  always_comb begin
    state_d    = state_q;
    org_c_d    = org_c_q;
    org_l_d    = org_l_q;
    w_d        = w_q;
    h_d        = h_q;
    base_d     = base_q;
    cnt_col_d  = cnt_col_q;
    cnt_line_d = cnt_line_q;
    buf_d      = buf_q;
    tag_vld_d  = tag_vld_q;
    tag_l_d    = tag_l_q;
    tag_w_d    = tag_w_q;
    adr_d      = adr_q;
    pix_d      = pix_q;
    ram_addr_d = ram_addr_q;
    err_d      = err_q;
    we_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          org_c_d    = coord_t'(pixel_c_I);
          org_l_d    = coord_t'(pixel_l_I);
          w_d        = (cache_w_I > W_MAX) ? W_MAX : cache_w_I;
          h_d        = (cache_h_I > H_MAX) ? H_MAX : cache_h_I;
          base_d     = im_addr_I;
          cnt_col_d  = '0;
          cnt_line_d = '0;
          tag_vld_d  = 1'b0;
          err_d      = 1'b0;
          state_d    = (cache_w_I == '0 || cache_h_I == '0) ? DONE : PIXEL;
        end
      end
      PIXEL: begin
        if (!in_img || hit) begin
          we_d       = 1'b1;
          pix_d      = in_img ? lane_pix : BORDER_VAL;
          ram_addr_d = {cnt_line_q[ADDR_SIZE_H-1:0], cnt_col_q[ADDR_SIZE_W-1:0]};
          if (cnt_col_q == w_q - 1'b1) begin
            if (cnt_line_q == h_q - 1'b1) begin
              state_d = DONE;
            end else begin
              cnt_col_d  = '0;
              cnt_line_d = cnt_line_q + 1'b1;
              tag_vld_d  = 1'b0;
            end
          end else begin
            cnt_col_d = cnt_col_q + 1'b1;
          end
        end else begin
          state_d = REQ;
          adr_d   = base_q + (((32'(unsigned'(cur_l)) * IM_WIDTH + 32'(unsigned'(cur_c))) / PPW) << 2);
        end
      end
      REQ: begin
`ifdef FILL_CACHE_PACK_ERR_EN
        if (p_wb_ERR_I) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else
`endif
        if (p_wb_ACK_I) begin
          buf_d     = p_wb_DAT_I;
          tag_vld_d = 1'b1;
          tag_l_d   = cur_l;
          tag_w_d   = widx;
          state_d   = PIXEL;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus strobes track the next state so a zero-latency ACK lands in the first REQ cycle.
    cyc_d   = (state_d == REQ);
    busy_d  = (state_d != IDLE);
    ready_d = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      org_c_q    <= '0;
      org_l_q    <= '0;
      w_q        <= '0;
      h_q        <= '0;
      base_q     <= '0;
      cnt_col_q  <= '0;
      cnt_line_q <= '0;
      buf_q      <= '0;
      tag_vld_q  <= 1'b0;
      tag_l_q    <= '0;
      tag_w_q    <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      cyc_q      <= 1'b0;
      adr_q      <= '0;
      we_q       <= 1'b0;
      pix_q      <= '0;
      ram_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      org_c_q    <= org_c_d;
      org_l_q    <= org_l_d;
      w_q        <= w_d;
      h_q        <= h_d;
      base_q     <= base_d;
      cnt_col_q  <= cnt_col_d;
      cnt_line_q <= cnt_line_d;
      buf_q      <= buf_d;
      tag_vld_q  <= tag_vld_d;
      tag_l_q    <= tag_l_d;
      tag_w_q    <= tag_w_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      cyc_q      <= cyc_d;
      adr_q      <= adr_d;
      we_q       <= we_d;
      pix_q      <= pix_d;
      ram_addr_q <= ram_addr_d;
      err_q      <= err_d;
    end
  end

  assign busy        = busy_q;
  assign cache_ready = ready_q;
  assign p_wb_CYC_O  = cyc_q;
  assign p_wb_STB_O  = cyc_q;
  assign p_wb_ADR_O  = adr_q;
  assign p_wb_LOCK_O = 1'b0;
  assign p_wb_SEL_O  = 4'hF;
  assign p_wb_WE_O   = 1'b0;
  assign pixels_out  = pix_q;
  assign ram_addr    = ram_addr_q;
  assign w_e         = we_q;
`ifdef FILL_CACHE_PACK_ERR_EN
  assign err         = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_fill_cache_pack.sv
// Self-checking bench for fill_cache_pack: table of tiles, random tiles and bus corner cases.
module tb_fill_cache_pack;

  logic               clk = 1'b0;
  logic               nRST;
  logic signed [10:0] pixel_c_I, pixel_l_I;
  logic [5:0]         cache_w_I, cache_h_I;
  logic [31:0]        im_addr_I;
  logic               go;
  logic               busy, cache_ready;
  logic [31:0]        dat;
  logic               ack;
  logic               stb, cyc, lock, we_o;
  logic [3:0]         sel;
  logic [31:0]        adr;
  logic [7:0]         pixels_out;
  logic [9:0]         ram_addr;
  logic               w_e;
`ifdef FILL_CACHE_PACK_ERR_EN
  logic               err_i, err;
`endif

  fill_cache_pack dut (
    .clk(clk), .nRST(nRST),
    .pixel_c_I(pixel_c_I), .pixel_l_I(pixel_l_I),
    .cache_w_I(cache_w_I), .cache_h_I(cache_h_I),
    .im_addr_I(im_addr_I), .go(go),
    .busy(busy), .cache_ready(cache_ready),
    .p_wb_DAT_I(dat), .p_wb_ACK_I(ack),
    .p_wb_STB_O(stb), .p_wb_CYC_O(cyc), .p_wb_LOCK_O(lock),
    .p_wb_SEL_O(sel), .p_wb_WE_O(we_o), .p_wb_ADR_O(adr),
    .pixels_out(pixels_out), .ram_addr(ram_addr),
`ifdef FILL_CACHE_PACK_ERR_EN
    .p_wb_ERR_I(err_i), .err(err),
`endif
    .w_e(w_e)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [9:0] a; logic [7:0] d; } wr_t;
  typedef struct {
    int c; int l; int w; int h; logic [31:0] base; int rd; int wr;
  } vec_t;

  int          tests = 0, fails = 0;
  wr_t         wr_q[$], exp_wr[$];
  logic [31:0] rd_q[$], exp_rd[$];
  int          lat_q[$];
  int          ready_cnt = 0, stab_err = 0, rd_n = 0, err_at = 0;
  logic [31:0] base_cur = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Image content, independent of how the DUT fetches it.
  function automatic logic [7:0] img_pix(input int l, input int c);
    return 8'(l * 37 + c * 11 + (c >> 5));
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int pi, l, c;
    pi = int'((a - base_cur) >> 2) * 4;
    l  = pi / 640;
    c  = pi % 640;
    return {img_pix(l, c + 3), img_pix(l, c + 2), img_pix(l, c + 1), img_pix(l, c)};
  endfunction

  // Expected writes and word reads for a tile, straight from the tile geometry.
  function automatic void build_model(input int c0, input int l0, input int w, input int h,
                                      input logic [31:0] base);
    int wc, hc;
    wc = (w > 32) ? 32 : w;
    hc = (h > 32) ? 32 : h;
    exp_wr.delete();
    exp_rd.delete();
    if (wc == 0 || hc == 0) return;
    for (int i = 0; i < hc; i++) begin
      int l, pw;
      l  = l0 + i;
      pw = -1;
      for (int j = 0; j < wc; j++) begin
        int c;
        wr_t e;
        c   = c0 + j;
        e.a = 10'(i * 32 + j);
        if (l >= 0 && l < 480 && c >= 0 && c < 640) begin
          e.d = img_pix(l, c);
          if (c / 4 != pw) begin
            exp_rd.push_back(base + 32'((l * 640 + c) / 4 * 4));
            pw = c / 4;
          end
        end else begin
          e.d = 8'h00;
        end
        exp_wr.push_back(e);
      end
    end
  endfunction

  // Wishbone slave with per-read latency (queued, else random 0..2).
  initial begin
    int wcnt, cur_lat;
    bit started;
    logic [31:0] hold_adr;
    ack = 1'b0; dat = '0; started = 1'b0; wcnt = 0; cur_lat = 0; hold_adr = '0;
`ifdef FILL_CACHE_PACK_ERR_EN
    err_i = 1'b0;
`endif
    forever begin
      @(posedge clk); #1;
`ifdef FILL_CACHE_PACK_ERR_EN
      if (ack || err_i) begin
        ack = 1'b0; err_i = 1'b0;
      end else
`else
      if (ack) begin
        ack = 1'b0;
      end else
`endif
      if (nRST && cyc && stb) begin
        if (!started) begin
          started  = 1'b1;
          wcnt     = 0;
          hold_adr = adr;
          cur_lat  = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(0, 2));
        end else if (adr !== hold_adr) begin
          stab_err++;
        end
        if (wcnt >= cur_lat) begin
          started = 1'b0;
          rd_n++;
`ifdef FILL_CACHE_PACK_ERR_EN
          if (rd_n == err_at) err_i = 1'b1;
          else begin
            ack = 1'b1; dat = mem_word(adr); rd_q.push_back(adr);
          end
`else
          ack = 1'b1; dat = mem_word(adr); rd_q.push_back(adr);
`endif
        end else begin
          wcnt++;
        end
      end else begin
        if (started && nRST) stab_err++;
        started = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (nRST && w_e) wr_q.push_back({ram_addr, pixels_out});
    if (nRST && cache_ready) ready_cnt++;
  end

  task automatic wait_ready(output int n);
    n = 0;
    while (ready_cnt == 0 && n < 6000) begin
      @(posedge clk);
      n++;
    end
  endtask

  task automatic start_tile(input int c0, input int l0, input int w, input int h,
                            input logic [31:0] base);
    wr_q.delete(); rd_q.delete();
    ready_cnt = 0; stab_err = 0; base_cur = base;
    pixel_c_I = 11'(c0); pixel_l_I = 11'(l0);
    cache_w_I = 6'(w);   cache_h_I = 6'(h);
    im_addr_I = base;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  task automatic run_tile(input string nm, input int c0, input int l0, input int w, input int h,
                          input logic [31:0] base, input int exp_rd_n, input int exp_wr_n,
                          input bit extra_go);
    int n;
    build_model(c0, l0, w, h, base);
    start_tile(c0, l0, w, h, base);
    check({nm, "_busy"}, 64'(busy), 64'd1);
    if (extra_go) begin
      repeat (3) @(posedge clk);
      #1 cache_w_I = 6'd0; pixel_c_I = 11'sd500; go = 1'b1;
      @(posedge clk); #1 go = 1'b0;
    end
    wait_ready(n);
    check({nm, "_timeout"}, 64'(n >= 6000), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check({nm, "_ready_pulses"}, 64'(ready_cnt), 64'd1);
    check({nm, "_busy_end"}, 64'(busy), 64'd0);
    check({nm, "_adr_stable"}, 64'(stab_err), 64'd0);
    if (exp_rd_n >= 0) check({nm, "_reads"}, 64'(rd_q.size()), 64'(exp_rd_n));
    if (exp_wr_n >= 0) check({nm, "_writes"}, 64'(wr_q.size()), 64'(exp_wr_n));
    check({nm, "_rd_model"}, 64'(rd_q.size()), 64'(exp_rd.size()));
    check({nm, "_wr_model"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
      check($sformatf("%s_rd_adr%0d", nm, i), 64'(rd_q[i]), 64'(exp_rd[i]));
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      check($sformatf("%s_wr%0d", nm, i), 64'(wr_q[i]), 64'(exp_wr[i]));
  endtask

  initial begin
    vec_t vecs[8];
    int n, found;
    vecs[0] = '{0,    0,   4,  4, 32'h1000, 4, 16};
    vecs[1] = '{-2,   -1,  4,  4, 32'h1000, 3, 16};
    vecs[2] = '{638,  478, 4,  4, 32'h2000, 2, 16};
    vecs[3] = '{0,    0,   0,  4, 32'h1000, 0, 0};
    vecs[4] = '{3,    10,  6,  2, 32'h0400, 6, 12};
    vecs[5] = '{0,    0,   40, 1, 32'h0000, 8, 32};
    vecs[6] = '{-40,  0,   32, 2, 32'h3000, 0, 64};
    vecs[7] = '{100,  600, 2,  2, 32'h3000, 0, 4};

    nRST = 1'b0; go = 1'b0;
    pixel_c_I = '0; pixel_l_I = '0; cache_w_I = '0; cache_h_I = '0; im_addr_I = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_ready", 64'(cache_ready), 64'd0);
    check("rst_cyc_stb", 64'({cyc, stb}), 64'd0);
    check("rst_we_lock", 64'({w_e, we_o, lock}), 64'd0);
    check("rst_sel", 64'(sel), 64'hF);
    check("rst_adr_ram", 64'({adr, ram_addr, pixels_out}), 64'd0);
    nRST = 1'b1;

    for (int v = 0; v < 8; v++)
      run_tile($sformatf("vec%0d", v), vecs[v].c, vecs[v].l, vecs[v].w, vecs[v].h,
               vecs[v].base, vecs[v].rd, vecs[v].wr, 1'b0);

    // Empty tile: cache_ready two cycles after go, no bus traffic.
    rd_q.delete(); ready_cnt = 0;
    cache_w_I = 6'd0; cache_h_I = 6'd4;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    found = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (cache_ready && found == 0) found = k;
    end
    check("empty_ready_lat", 64'(found), 64'd2);
    check("empty_reads", 64'(rd_q.size()), 64'd0);

    // go while busy is ignored.
    run_tile("busy_go", 0, 0, 4, 4, 32'h1000, 4, 16, 1'b1);

    // Long ACK wait then zero-latency ACK.
    lat_q = '{5, 0};
    run_tile("slow_ack", 0, 0, 4, 4, 32'h1000, 4, 16, 1'b0);
    lat_q.delete();

    // Reset while a read is outstanding.
    lat_q = '{20};
    start_tile(0, 0, 4, 4, 32'h1000);
    n = 0;
    while (!cyc && n < 100) begin @(posedge clk); n++; end
    check("rst_req_seen", 64'(cyc), 64'd1);
    @(negedge clk); #2 nRST = 1'b0;
    #1;
    check("rst_async_cyc_stb", 64'({cyc, stb}), 64'd0);
    check("rst_async_busy", 64'(busy), 64'd0);
    lat_q.delete();
    repeat (2) @(posedge clk);
    #1 nRST = 1'b1;
    run_tile("after_rst", 0, 0, 4, 4, 32'h1000, 4, 16, 1'b0);

`ifdef FILL_CACHE_PACK_ERR_EN
    rd_n = 0; err_at = 2;
    start_tile(0, 0, 4, 4, 32'h1000);
    wait_ready(n);
    repeat (4) @(posedge clk);
    #1;
    check("err_timeout", 64'(n >= 6000), 64'd0);
    check("err_flag", 64'(err), 64'd1);
    check("err_writes", 64'(wr_q.size()), 64'd4);
    check("err_ready", 64'(ready_cnt), 64'd1);
    check("err_cyc", 64'(cyc), 64'd0);
    err_at = 0;
    start_tile(0, 0, 0, 1, 32'h1000);
    wait_ready(n);
    #1;
    check("err_cleared", 64'(err), 64'd0);
    repeat (3) @(posedge clk);
`endif

    for (int r = 0; r < 20; r++) begin
      int c0, l0, w, h;
      c0 = int'($urandom_range(0, 720)) - 40;
      l0 = int'($urandom_range(0, 560)) - 40;
      w  = int'($urandom_range(0, 40));
      h  = int'($urandom_range(0, 8));
      run_tile($sformatf("rnd%0d", r), c0, l0, w, h, 32'($urandom_range(0, 65535)) << 2,
               -1, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
